// File: rtl/demux_1_2_buf_if.sv
// Bundles the signals of the demultiplexer: one valid/ready input stream
// steered by sel, two buffered valid/ready output lanes, and the per-lane
// delivered-word counters.
//   slave  : the demultiplexer itself (consumes in_*, drives out*_* and cnt*)
//   master : the environment (producer plus both consumers)
interface demux_1_2_buf_if #(
    parameter int WIDTH = 3,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             sel;
    logic             out0_valid;
    logic             out0_ready;
    logic [WIDTH-1:0] out0_data;
    logic             out1_valid;
    logic             out1_ready;
    logic [WIDTH-1:0] out1_data;
    logic [CNT_W-1:0] cnt0;
    logic [CNT_W-1:0] cnt1;

    modport slave (
        input  in_valid, in_data, sel, out0_ready, out1_ready,
        output in_ready, out0_valid, out0_data, out1_valid, out1_data, cnt0, cnt1
    );

    modport master (
        output in_valid, in_data, sel, out0_ready, out1_ready,
        input  in_ready, out0_valid, out0_data, out1_valid, out1_data, cnt0, cnt1
    );
endinterface

// File: rtl/demux_1_2_buf.sv
// Registered 1-to-2 demultiplexer. Each input word is written into the FIFO
// of the lane chosen by sel; each lane drains independently through its own
// valid/ready handshake, so a stalled consumer never blocks the other lane.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; empties both lanes, clears counters
//   bus    demux_1_2_buf_if.slave:
//            in_valid/in_ready/in_data/sel   producer side
//            out0_* / out1_*                 consumer lanes (head word + valid)
//            cnt0 / cnt1                     words delivered per lane (wrapping)
module demux_1_2_buf #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 2,   // power of two, at least 2
    parameter int CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    demux_1_2_buf_if.slave        bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    logic [1:0]            full;
    logic [1:0]            empty;
    logic [1:0]            push;
    logic [1:0]            pop;
    logic [1:0]            lane_ready;
    logic [1:0][WIDTH-1:0] head;
    logic [1:0][CNT_W-1:0] cnt;

    // Acceptance looks only at the selected lane's stored occupancy; a pop in
    // the same cycle does not make room for the incoming word.
    assign bus.in_ready = ~full[bus.sel];

    assign lane_ready = {bus.out1_ready, bus.out0_ready};
    assign push[0]    = bus.in_valid & bus.in_ready & ~bus.sel;
    assign push[1]    = bus.in_valid & bus.in_ready &  bus.sel;
    assign pop        = ~empty & lane_ready;

    for (genvar l = 0; l < 2; l++) begin : g_lane
        logic [PTR_W-1:0] wr_ptr;
        logic [PTR_W-1:0] rd_ptr;
        logic [OCC_W-1:0] occ;
        logic [WIDTH-1:0] mem [DEPTH];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                occ    <= '0;
                cnt[l] <= '0;
                // NOTE: storage is cleared too so the head word reads 0 out of
                // reset; the lane is tiny, so this costs nothing meaningful.
                for (int i = 0; i < DEPTH; i++) begin
                    mem[i] <= '0;
                end
            end else begin
                // NOTE: all state here uses non-blocking assignments so every
                // register samples pre-edge values regardless of statement order.
                if (push[l]) begin
                    mem[wr_ptr] <= bus.in_data;
                    wr_ptr      <= wr_ptr + 1'b1;   // wraps modulo DEPTH
                end
                if (pop[l]) begin
                    rd_ptr <= rd_ptr + 1'b1;
                    cnt[l] <= cnt[l] + 1'b1;        // wraps modulo 2^CNT_W
                end
                // Simultaneous push and pop leaves occupancy unchanged.
                case ({push[l], pop[l]})
                    2'b10:   occ <= occ + 1'b1;
                    2'b01:   occ <= occ - 1'b1;
                    default: occ <= occ;
                endcase
            end
        end

        assign full[l]  = (occ == OCC_W'(DEPTH));
        assign empty[l] = (occ == '0);
        assign head[l]  = mem[rd_ptr];
    end

    assign bus.out0_valid = ~empty[0];
    assign bus.out1_valid = ~empty[1];
    assign bus.out0_data  = head[0];
    assign bus.out1_data  = head[1];
    assign bus.cnt0       = cnt[0];
    assign bus.cnt1       = cnt[1];
endmodule

// File: tb/tb_demux_1_2_buf.sv
module tb_demux_1_2_buf;
    localparam int WIDTH = 3;
    localparam int DEPTH = 2;
    localparam int CNT_W = 8;

    logic clk;
    logic rst_n;
    int   vectors = 0;
    int   miscompares = 0;

    demux_1_2_buf_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    demux_1_2_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: one queue per lane plus delivered-word tallies.
    logic [WIDTH-1:0] q0 [$];
    logic [WIDTH-1:0] q1 [$];
    int unsigned      m_cnt0 = 0;
    int unsigned      m_cnt1 = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q0.delete();
            q1.delete();
            m_cnt0 = 0;
            m_cnt1 = 0;
        end else begin
            bit acc0, acc1, take0, take1;
            acc0  = bus.in_valid && !bus.sel && (q0.size() < DEPTH);
            acc1  = bus.in_valid &&  bus.sel && (q1.size() < DEPTH);
            take0 = (q0.size() > 0) && bus.out0_ready;
            take1 = (q1.size() > 0) && bus.out1_ready;
            if (take0) begin void'(q0.pop_front()); m_cnt0 = (m_cnt0 + 1) % 256; end
            if (take1) begin void'(q1.pop_front()); m_cnt1 = (m_cnt1 + 1) % 256; end
            if (acc0) q0.push_back(bus.in_data);
            if (acc1) q1.push_back(bus.in_data);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("in_ready", 32'(bus.in_ready),
              32'(((bus.sel ? q1.size() : q0.size()) < DEPTH)));
        check("out0_valid", 32'(bus.out0_valid), 32'(q0.size() > 0));
        check("out1_valid", 32'(bus.out1_valid), 32'(q1.size() > 0));
        if (q0.size() > 0) check("out0_data", 32'(bus.out0_data), 32'(q0[0]));
        if (q1.size() > 0) check("out1_data", 32'(bus.out1_data), 32'(q1[0]));
        check("cnt0", 32'(bus.cnt0), m_cnt0);
        check("cnt1", 32'(bus.cnt1), m_cnt1);
    end

    // Producer rule: a refused word must be held until it is accepted.
    logic             prev_stall = 1'b0;
    logic [WIDTH-1:0] prev_data  = '0;
    logic             prev_sel   = 1'b0;
    always @(posedge clk) begin
        if (rst_n && prev_stall && bus.in_valid)
            assert (bus.in_data == prev_data && bus.sel == prev_sel)
                else $error("producer changed word while stalled");
        prev_stall = rst_n && bus.in_valid && !bus.in_ready;
        prev_data  = bus.in_data;
        prev_sel   = bus.sel;
    end

    // Apply one cycle of inputs; returns 1 time unit after the edge that used them.
    task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic s,
                        input logic r0, input logic r1);
        bus.in_valid   = v;
        bus.in_data    = d;
        bus.sel        = s;
        bus.out0_ready = r0;
        bus.out1_ready = r1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n          = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.sel        = 1'b0;
        bus.out0_ready = 1'b0;
        bus.out1_ready = 1'b0;

        // Reset and idle.
        step(0, 3'b000, 0, 0, 0);
        step(0, 3'b000, 0, 0, 0);
        check("rst out0_valid", 32'(bus.out0_valid), 0);
        check("rst out1_valid", 32'(bus.out1_valid), 0);
        check("rst out0_data",  32'(bus.out0_data),  0);
        check("rst out1_data",  32'(bus.out1_data),  0);
        check("rst cnt0",       32'(bus.cnt0),       0);
        check("rst cnt1",       32'(bus.cnt1),       0);
        check("rst in_ready",   32'(bus.in_ready),   1);
        @(negedge clk);
        #2 rst_n = 1'b1;
        step(0, 3'b000, 0, 0, 0);

        // Single word to lane 0, one-cycle latency.
        step(1, 3'b110, 0, 0, 0);
        check("t2 out0_valid", 32'(bus.out0_valid), 1);
        check("t2 out0_data",  32'(bus.out0_data),  32'b110);
        check("t2 out1_valid", 32'(bus.out1_valid), 0);
        check("t2 cnt0",       32'(bus.cnt0),       0);
        step(0, 3'b000, 0, 1, 0);
        check("t2 cnt0 after pop", 32'(bus.cnt0), 1);

        // Fill lane 1, flip sel, drain in order.
        step(1, 3'b010, 1, 0, 0);
        step(1, 3'b101, 1, 0, 0);
        step(0, 3'b000, 1, 0, 0);
        check("t3 in_ready full", 32'(bus.in_ready), 0);
        check("t3 head",          32'(bus.out1_data), 32'b010);
        bus.sel = 1'b0;
        #1;
        check("t3 in_ready sel0", 32'(bus.in_ready), 1);
        step(0, 3'b000, 0, 0, 1);
        check("t3 second word", 32'(bus.out1_data), 32'b101);
        check("t3 cnt1 one",    32'(bus.cnt1),      1);
        step(0, 3'b000, 0, 0, 1);
        check("t3 cnt1 two",    32'(bus.cnt1),      2);
        check("t3 drained",     32'(bus.out1_valid), 0);

        // Lane 0 full and stalled; lane 1 still flows.
        step(1, 3'b001, 0, 0, 0);
        step(1, 3'b011, 0, 0, 0);
        check("t4 in_ready lane0 full", 32'(bus.in_ready), 0);
        step(1, 3'b111, 1, 0, 0);
        check("t4 out1_valid", 32'(bus.out1_valid), 1);
        check("t4 out1_data",  32'(bus.out1_data),  32'b111);
        check("t4 out0_data",  32'(bus.out0_data),  32'b001);
        step(0, 3'b000, 0, 0, 1);
        check("t4 cnt1",       32'(bus.cnt1),       3);
        check("t4 out0 held",  32'(bus.out0_data),  32'b001);
        step(0, 3'b000, 0, 1, 0);
        check("t4 lane0 next", 32'(bus.out0_data),  32'b011);
        step(0, 3'b000, 0, 1, 0);
        check("t4 cnt0",       32'(bus.cnt0),       3);

        // Pops on both lanes in one cycle.
        step(1, 3'b100, 0, 0, 0);
        step(1, 3'b101, 1, 0, 0);
        step(0, 3'b000, 0, 1, 1);
        check("both cnt0", 32'(bus.cnt0), 4);
        check("both cnt1", 32'(bus.cnt1), 4);

        // Streaming through lane 0 at occupancy 1; counter wraps.
        step(1, 3'b000, 0, 0, 0);
        for (int i = 0; i < 252; i++) begin
            step(1, 3'((i + 1) % 8), 0, 1, 0);
            if (i == 250) check("stream cnt0 255", 32'(bus.cnt0), 255);
        end
        check("stream cnt0 wrap", 32'(bus.cnt0), 0);
        check("stream occ 1",     32'(bus.out0_valid), 1);

        // Full lane refuses input even while popping.
        step(1, 3'b001, 1, 0, 0);
        step(1, 3'b010, 1, 0, 0);
        step(1, 3'b110, 1, 0, 1);
        check("nopass head", 32'(bus.out1_data), 32'b010);
        check("nopass cnt1", 32'(bus.cnt1),      5);
        step(1, 3'b110, 1, 0, 0);
        step(0, 3'b000, 0, 0, 0);
        check("pre-rst lane0", 32'(bus.out0_valid), 1);
        check("pre-rst lane1", 32'(bus.out1_valid), 1);

        // Asynchronous reset mid-stream.
        #3 rst_n = 1'b0;
        #1;
        check("arst out0_valid", 32'(bus.out0_valid), 0);
        check("arst out1_valid", 32'(bus.out1_valid), 0);
        check("arst out0_data",  32'(bus.out0_data),  0);
        check("arst out1_data",  32'(bus.out1_data),  0);
        check("arst cnt0",       32'(bus.cnt0),       0);
        check("arst cnt1",       32'(bus.cnt1),       0);
        check("arst in_ready",   32'(bus.in_ready),   1);
        step(0, 3'b000, 0, 1, 1);
        @(negedge clk);
        #2 rst_n = 1'b1;
        step(0, 3'b000, 0, 1, 1);
        step(0, 3'b000, 0, 1, 1);
        check("post-rst out0_valid", 32'(bus.out0_valid), 0);
        check("post-rst out1_valid", 32'(bus.out1_valid), 0);
        check("post-rst cnt0",       32'(bus.cnt0),       0);
        check("post-rst cnt1",       32'(bus.cnt1),       0);

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/demux_1_2_buf.md
Name: demux_1_2_buf

Overview:
- Registered 1-to-2 demultiplexer. It is the distribution counterpart of the team's 2:1 selector.
- One valid/ready input stream of WIDTH-bit words is steered by `sel` into one of two independent output lanes.
- Each lane has its own FIFO and its own valid/ready handshake.
- Sits between a single producer and two consumers. A stall on one lane never blocks traffic destined for the other lane.

Parameters:
- WIDTH, 3, data word width in bits.
- DEPTH, 2, entries per lane FIFO. Must be a power of 2, minimum 2.
- CNT_W, 8, width of the per-lane delivered-word counters.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous and active-low.
- in_valid  input  1  producer has a word on in_data.
- in_ready  output  1  block can accept the word for the lane chosen by sel.
- in_data  input  WIDTH  input word.
- sel  input  1  destination lane: 0 selects lane 0, 1 selects lane 1. Sampled together with in_data.
- out0_valid  output  1  lane 0 FIFO non-empty.
- out0_ready  input  1  lane 0 consumer accepts.
- out0_data  output  WIDTH  lane 0 head word.
- out1_valid  output  1  lane 1 FIFO non-empty.
- out1_ready  input  1  lane 1 consumer accepts.
- out1_data  output  WIDTH  lane 1 head word.
- cnt0  output  CNT_W  words delivered on lane 0.
- cnt1  output  CNT_W  words delivered on lane 1.

Behaviour:
- Reset (rst_n low, takes effect immediately, no clock needed):
  - both FIFOs empty; out0_valid = out1_valid = 0.
  - out0_data = out1_data = 0.
  - cnt0 = cnt1 = 0.
  - in_ready reflects the empty FIFOs, so it reads 1.
  - Reset asserted mid-operation discards all buffered words; nothing is delivered after release.
- in_ready:
  - combinational: in_ready = NOT full[sel].
  - It does not depend on in_valid or on the out*_ready inputs.
  - There is no same-cycle pass-through: a full lane refuses input even while it is popping in that cycle.
- Push: on a rising edge with in_valid & in_ready, in_data is written to the tail of FIFO[sel].
- Latency: a word accepted at edge N appears on outS_data with outS_valid = 1 immediately after edge N, provided lane S was empty. Minimum latency is 1 cycle.
- Output valid/data: outS_valid = NOT empty[S]; outS_data = FIFO[S] head. Head data is driven from storage, with no combinational path from in_data.
- Pop: on a rising edge with outS_valid & outS_ready, the head word of lane S is removed and cntS increments by 1.
- Counters: cntS wraps modulo 2^CNT_W, e.g. 255 -> 0 when CNT_W = 8.
- Handshake rules:
  - A lane keeps outS_valid high and outS_data stable until the word is accepted.
  - The producer must hold in_data/sel stable while in_valid & !in_ready. The bench checks this with an assertion.
- Simultaneous events:
  - Push and pop on the same non-full lane in one cycle: occupancy is unchanged and order is preserved.
  - Push to one lane and pop on the other in the same cycle are fully independent.
  - Pops on both lanes in the same cycle: both counters increment.
- Ordering: per-lane FIFO order is strict. There is no ordering guarantee between lanes.
- Full/empty:
  - occupancy is tracked per lane (clog2(DEPTH)+1 bits).
  - full = (occ == DEPTH); empty = (occ == 0).
  - Read and write pointers wrap modulo DEPTH.
- in_valid with in_ready low: no state change and no word lost. Caller retries.

Test Plan:
- Reset then idle, all ready = 0 -> out0_valid = out1_valid = 0, out*_data = 0, cnt0 = cnt1 = 0, in_ready = 1.
- Push 3'b110 with sel = 0, out0_ready = 0 -> out0_valid = 1, out0_data = 110 one cycle later; out1_valid stays 0; cnt0 = 0.
- Push 3'b010 then 3'b101 with sel = 1, out1_ready = 0 -> lane 1 full and in_ready = 0 while sel = 1. Flip sel to 0 -> in_ready = 1. Then set out1_ready = 1 -> 010 then 101 delivered in order, cnt1 = 2.
- Lane 0 stalled and full (DEPTH = 2, words 001, 011), sel = 0 -> in_ready = 0. A push with sel = 1 of 111 is accepted and delivered on lane 1 while lane 0 holds 001 unchanged.
- Lane 0 holding one word with out0_ready = 1 and in_valid = 1 every cycle with sel = 0 -> one word per cycle delivered, occupancy constant at 1. After 256 deliveries cnt0 wraps to 0.
- Assert rst_n low mid-stream with both lanes holding words -> outputs clear immediately without a clock edge. After release no stale words appear and counters read 0.
